// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared word width, fetch FSM states, buffer entry type and reset vector
package cpu_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        HALT    = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    // Word addresses wrap naturally from all-ones back to zero.
    function automatic logic [WORD_W-1:0] next_word_addr(input logic [WORD_W-1:0] addr);
        return addr + WORD_W'(1);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - in-order instruction buffer (depth 1 or 2) with push/pop/flush
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  fetch_entry_t     push_entry_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     slot_q [DEPTH];
    fetch_entry_t     slot_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A pop frees the slot the push needs, so both may land on a full buffer.
    assign push_ok = push_i && (!full || pop_ok);

    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            if (pop_ok) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    slot_d[i] = slot_q[i + 1];
                end
                count_d = count_d - CNT_W'(1);
            end
            if (push_ok) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == count_d) begin
                        slot_d[i] = push_entry_i;
                    end
                end
                count_d = count_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
        end
    end

    assign head_o  = slot_q[0];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM feeding IR; FETCH_PREFETCH_EN selects a 2-entry buffer
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stop_i,
    input  logic              redirect_i,
    input  logic [WORD_W-1:0] redirect_pc_i,
    output logic              mem_read_o,
    output logic [WORD_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [WORD_W-1:0] mem_data_i,
    output logic [WORD_W-1:0] ir_o,
    output logic              ir_valid_o,
    input  logic              ir_take_i,
    output logic [WORD_W-1:0] fetch_pc_o
);

`ifdef FETCH_PREFETCH_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [WORD_W-1:0] fp_q;
    logic [WORD_W-1:0] fp_d;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] addr_d;
    logic [CNT_W-1:0]  buf_count;
    logic              buf_empty;
    fetch_entry_t      buf_head;
    fetch_entry_t      push_entry;
    logic              push;
    logic              pop;
    logic              issue;
    logic [OCC_W-1:0]  occ_next;
    logic              space_next;

    // Redirect overrides any take in the same cycle; data returned on a redirect is stale.
    assign pop        = ir_take_i && !buf_empty && !redirect_i;
    assign push       = (state_q == FETCH) && mem_ack_i && !redirect_i;
    assign push_entry = '{instr: mem_data_i, pc: addr_q};

    // Occupancy after this edge decides whether a new request may be issued.
    assign occ_next   = redirect_i ? '0
                      : ({1'b0, buf_count} - OCC_W'(pop) + OCC_W'(push));
    assign space_next = (occ_next < OCC_W'(BUF_DEPTH));

    always_comb begin
        state_d = state_q;
        fp_d    = redirect_i ? redirect_pc_i : fp_q;
        addr_d  = addr_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (stop_i) begin
                    state_d = HALT;
                end else if (space_next) begin
                    issue = 1'b1;
                end
            end
            FETCH, DISCARD: begin
                if (mem_ack_i) begin
                    if (push) begin
                        fp_d = next_word_addr(fp_q);
                    end
                    if (stop_i) begin
                        state_d = HALT;
                    end else if (space_next) begin
                        issue = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (redirect_i) begin
                    state_d = DISCARD;
                end
            end
            HALT: begin
                if (!stop_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            state_d = FETCH;
            addr_d  = fp_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            fp_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            fp_q    <= fp_d;
            addr_q  <= addr_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect_i),
        .head_o       (buf_head),
        .empty_o      (buf_empty),
        .count_o      (buf_count)
    );

    assign mem_read_o = (state_q == FETCH) || (state_q == DISCARD);
    assign mem_addr_o = addr_q;
    assign ir_o       = buf_head.instr;
    assign fetch_pc_o = buf_head.pc;
    assign ir_valid_o = !buf_empty;

endmodule
